// File: rtl/irq_exc_ctrl_if.sv
// Core-side bundle for irq_exc_ctrl: interrupt lines, mask access, trap
// redirect and status. master = core, slave = controller.
interface irq_exc_ctrl_if #(
  parameter int unsigned NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] iIrq;
  logic [NUM_IRQ-1:0] iIrqAck;
  logic               iMaskWe;
  logic [NUM_IRQ-1:0] iMaskData;
  logic [31:0]        iPC;
  logic               iUndefInst;
  logic               iEret;
  logic               iStall;
  logic               oTakeTrap;
  logic [31:0]        oTrapVector;
  logic [31:0]        oEpc;
  logic [4:0]         oCause;
  logic [NUM_IRQ-1:0] oPending;
  logic [NUM_IRQ-1:0] oMask;
  logic               oKernelMode;
  logic               oFatal;

  modport master (
    output iIrq, iIrqAck, iMaskWe, iMaskData, iPC, iUndefInst, iEret, iStall,
    input  oTakeTrap, oTrapVector, oEpc, oCause, oPending, oMask, oKernelMode, oFatal
  );

  modport slave (
    input  iIrq, iIrqAck, iMaskWe, iMaskData, iPC, iUndefInst, iEret, iStall,
    output oTakeTrap, oTrapVector, oEpc, oCause, oPending, oMask, oKernelMode, oFatal
  );
endinterface

// File: rtl/irq_exc_ctrl.sv
// Interrupt/exception controller: edge-latched pending bits, mask, priority,
// user/kernel FSM and one-cycle trap redirect. Optional macro IRQ_SYNC_EN.
module irq_exc_ctrl #(
  parameter int unsigned        NUM_IRQ    = 4,
  parameter logic [31:0]        IRQ_VECTOR = 32'h80000004,
  parameter logic [31:0]        EXC_VECTOR = 32'h80000008,
  parameter logic [NUM_IRQ-1:0] MASK_RESET = '1
) (
  input logic           clk,
  input logic           reset,
  irq_exc_ctrl_if.slave bus
);

  typedef enum logic {S_USER, S_KERNEL} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] hist_q, hist_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [4:0]         cause_q, cause_d;
  logic               fatal_q, fatal_d;
  logic               eret_block_q, eret_block_d;

  logic [NUM_IRQ-1:0] irq_in;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] irq_active;
  logic [3:0]         irq_idx;
  logic               req_irq;
  logic               req_exc;
  logic               take_trap;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync1_d;
  logic [NUM_IRQ-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.iIrq;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_in = sync2_q;
`else
  assign irq_in = bus.iIrq;
`endif

  always_comb begin
    irq_rise   = irq_in & ~hist_q;
    irq_active = pending_q & mask_q;
    req_irq    = |irq_active;
    req_exc    = bus.iUndefInst;

    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_active[i]) irq_idx = 4'(i);
    end

    // The cycle right after eret belongs to the returning user instruction.
    take_trap = ~reset & (state_q == S_USER) & ~eret_block_q & ~bus.iStall
              & (req_exc | req_irq);

    hist_d       = irq_in;
    pending_d    = (pending_q & ~bus.iIrqAck) | irq_rise;
    mask_d       = bus.iMaskWe ? bus.iMaskData : mask_q;
    state_d      = state_q;
    cause_d      = cause_q;
    fatal_d      = fatal_q;
    eret_block_d = 1'b0;

    case (state_q)
      S_USER: begin
        if (take_trap) begin
          state_d = S_KERNEL;
          cause_d = req_exc ? 5'b10000 : {1'b0, irq_idx};
        end
      end
      S_KERNEL: begin
        if (bus.iEret) begin
          state_d      = S_USER;
          eret_block_d = 1'b1;
        end
        if (req_exc) fatal_d = 1'b1;
      end
      default: state_d = S_USER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_USER;
      hist_q       <= '0;
      pending_q    <= '0;
      mask_q       <= MASK_RESET;
      cause_q      <= '0;
      fatal_q      <= 1'b0;
      eret_block_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      cause_q      <= cause_d;
      fatal_q      <= fatal_d;
      eret_block_q <= eret_block_d;
    end
  end

  // Exceptions skip the faulting instruction; interrupts replay the squashed one.
  assign bus.oTakeTrap   = take_trap;
  assign bus.oTrapVector = take_trap ? (req_exc ? EXC_VECTOR : IRQ_VECTOR) : '0;
  assign bus.oEpc        = take_trap ? (req_exc ? bus.iPC + 32'd4 : bus.iPC) : '0;
  assign bus.oCause      = cause_q;
  assign bus.oPending    = pending_q;
  assign bus.oMask       = mask_q;
  assign bus.oKernelMode = (state_q == S_KERNEL);
  assign bus.oFatal      = fatal_q;

endmodule

// File: tb/tb_irq_exc_ctrl.sv
// Scoreboard bench for irq_exc_ctrl: directed stimulus pushes expected traps,
// a negedge monitor pops and checks each redirect and the following cause.
module tb_irq_exc_ctrl;
  localparam int unsigned NUM_IRQ = 4;
  localparam logic [31:0] IRQ_VEC = 32'h80000004;
  localparam logic [31:0] EXC_VEC = 32'h80000008;

  typedef struct {
    int         cyc;
    logic [31:0] vec;
    logic [31:0] epc;
    logic [4:0]  cause;
  } trap_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  trap_t exp_q[$];
  logic       cause_check_pending = 1'b0;
  logic [4:0] exp_cause = '0;

  irq_exc_ctrl_if #(.NUM_IRQ(NUM_IRQ)) bus ();

  irq_exc_ctrl #(
    .NUM_IRQ(NUM_IRQ),
    .IRQ_VECTOR(IRQ_VEC),
    .EXC_VECTOR(EXC_VEC),
    .MASK_RESET(4'b1111)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expectTrap(input int c, input logic [31:0] vec, input logic [31:0] epc,
                            input logic [4:0] cause);
    trap_t t;
    t.cyc = c; t.vec = vec; t.epc = epc; t.cause = cause;
    exp_q.push_back(t);
  endtask

  // Drive one cycle of inputs, then move to just after the next rising edge.
  task automatic applyStimulus(input logic [3:0] irq, input logic [3:0] ack, input logic mask_we,
                               input logic [3:0] mask_data, input logic [31:0] pc,
                               input logic undef, input logic eret, input logic stall);
    bus.iIrq       = irq;
    bus.iIrqAck    = ack;
    bus.iMaskWe    = mask_we;
    bus.iMaskData  = mask_data;
    bus.iPC        = pc;
    bus.iUndefInst = undef;
    bus.iEret      = eret;
    bus.iStall     = stall;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    trap_t t;
    if (cause_check_pending) begin
      cause_check_pending = 1'b0;
      checkOutput("trapCause", 64'(bus.oCause), 64'(exp_cause));
      checkOutput("trapKernel", 64'(bus.oKernelMode), 64'd1);
    end
    if (bus.oTakeTrap) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpectedTrap", 64'(bus.oTakeTrap), 64'd0);
      end else begin
        t = exp_q.pop_front();
        checkOutput("trapCycle", 64'(cyc), 64'(t.cyc));
        checkOutput("trapVector", 64'(bus.oTrapVector), 64'(t.vec));
        checkOutput("trapEpc", 64'(bus.oEpc), 64'(t.epc));
        exp_cause = t.cause;
        cause_check_pending = 1'b1;
      end
    end else begin
      checkOutput("idleVecEpc", {bus.oTrapVector, bus.oEpc}, 64'd0);
    end
  end

  initial begin
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("rstPending", 64'(bus.oPending), 64'd0);
    checkOutput("rstMask", 64'(bus.oMask), 64'hF);
    checkOutput("rstCause", 64'(bus.oCause), 64'd0);
    checkOutput("rstFatal", 64'(bus.oFatal), 64'd0);
    checkOutput("rstKernel", 64'(bus.oKernelMode), 64'd0);

    // Channel 2 edge, trap one cycle later with EPC = squashed PC.
    expectTrap(cyc + 1, IRQ_VEC, 32'h00400010, 5'b00010);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h00400010, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h00400010, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0100, 1'b0, 4'b0000, 32'h80000004, 1'b0, 1'b0, 1'b0);
    checkOutput("t1Kernel", 64'(bus.oKernelMode), 64'd1);
    checkOutput("t1AckClear", 64'(bus.oPending), 64'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h80000008, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h00400010, 1'b0, 1'b0, 1'b0);
    checkOutput("t1User", 64'(bus.oKernelMode), 64'd0);

    // Channels 3 and 1 together, then an undefined instruction at the wrap boundary.
    applyStimulus(4'b1010, 4'b0000, 1'b0, 4'b0000, 32'h00400100, 1'b0, 1'b0, 1'b0);
    expectTrap(cyc, EXC_VEC, 32'h00000000, 5'b10000);
    applyStimulus(4'b1010, 4'b0000, 1'b0, 4'b0000, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b1010, 4'b0000, 1'b0, 4'b0000, 32'h80000008, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b1010, 4'b0000, 1'b0, 4'b0000, 32'h00400200, 1'b0, 1'b0, 1'b0);
    checkOutput("t2Pending", 64'(bus.oPending), 64'hA);
    expectTrap(cyc, IRQ_VEC, 32'h00400204, 5'b00001);
    applyStimulus(4'b1010, 4'b0000, 1'b0, 4'b0000, 32'h00400204, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b1010, 1'b0, 4'b0000, 32'h80000004, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h00400204, 1'b0, 1'b0, 1'b0);
    checkOutput("t2Pending0", 64'(bus.oPending), 64'd0);
    checkOutput("t2User", 64'(bus.oKernelMode), 64'd0);

    // Masked channel 0 latches but does not trap until unmasked.
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b1110, 32'h00400300, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0000, 32'h00400304, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0000, 32'h00400308, 1'b0, 1'b0, 1'b0);
    checkOutput("t3Pending", 64'(bus.oPending), 64'h1);
    checkOutput("t3Mask", 64'(bus.oMask), 64'hE);
    expectTrap(cyc + 1, IRQ_VEC, 32'h0040030C, 5'b00000);
    applyStimulus(4'b0001, 4'b0000, 1'b1, 4'b1111, 32'h0040030C, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0000, 32'h0040030C, 1'b0, 1'b0, 1'b0);

    // Kernel mode: new edge plus undefined instruction -> fatal, no trap.
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h80000004, 1'b1, 1'b0, 1'b0);
    checkOutput("t4Fatal", 64'(bus.oFatal), 64'd1);
    checkOutput("t4Kernel", 64'(bus.oKernelMode), 64'd1);
    checkOutput("t4Pending", 64'(bus.oPending), 64'h5);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h80000008, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h8000000C, 1'b0, 1'b0, 1'b0);
    checkOutput("t4FatalSticky", 64'(bus.oFatal), 64'd1);
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h80000010, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("t4RstKernel", 64'(bus.oKernelMode), 64'd0);
    checkOutput("t4RstPending", 64'(bus.oPending), 64'd0);
    checkOutput("t4RstFatal", 64'(bus.oFatal), 64'd0);
    checkOutput("t4RstMask", 64'(bus.oMask), 64'hF);

    // Stall holds channel 2 for three cycles; then ack racing a new edge.
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h00400400, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h00400400, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h00400400, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h00400400, 1'b0, 1'b0, 1'b1);
    checkOutput("t5StallPending", 64'(bus.oPending), 64'h4);
    expectTrap(cyc, IRQ_VEC, 32'h00400400, 5'b00010);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h00400400, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h80000004, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 4'b0100, 1'b0, 4'b0000, 32'h80000008, 1'b0, 1'b0, 1'b0);
    checkOutput("t5SetWins", 64'(bus.oPending), 64'h4);
    applyStimulus(4'b0100, 4'b0100, 1'b0, 4'b0000, 32'h8000000C, 1'b0, 1'b0, 1'b0);
    checkOutput("t5AckOnly", 64'(bus.oPending), 64'd0);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h80000010, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h00400400, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h00400404, 1'b0, 1'b0, 1'b0);
    checkOutput("t5User", 64'(bus.oKernelMode), 64'd0);
    checkOutput("queueEmpty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
